// File: rtl/ether_pkg.sv
// Shared types and constants for the RMII Ethernet frame transmitter.
// Holds frame section lengths, preamble/SFD dibits and CRC-32 constants.
package ether_pkg;

   localparam int unsigned CNT_W           = 9;
   localparam int unsigned PREAMBLE_DIBITS = 32;
   localparam int unsigned HEADER_DIBITS   = 56;
   localparam int unsigned PAYLOAD_DIBITS  = 184;
   localparam int unsigned FCS_DIBITS      = 16;
   localparam int unsigned IFG_CYCLES      = 48;
   localparam int unsigned WORD_BYTES      = 4;
   localparam int unsigned HDR_W           = 112;

   localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
   localparam logic [1:0]  SFD_DIBIT      = 2'b11;

   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      HEADER,
      PAYLOAD,
      FCS,
      IFG
   } state_t;

   // Bytes go out on the wire least-significant dibit first.
   function automatic logic [1:0] byte_dibit(input logic [7:0] b, input logic [1:0] sel);
      logic [1:0] d;
      case (sel)
         2'd0:    d = b[1:0];
         2'd1:    d = b[3:2];
         2'd2:    d = b[5:4];
         default: d = b[7:6];
      endcase
      return d;
   endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Combinational CRC-32 (reflected) advance by one RMII dibit.
// Bit [0] of the dibit is the first bit on the wire.
module crc32_dibit
   import ether_pkg::*;
(
   input  logic [31:0] crc,
   input  logic [1:0]  dibit,
   output logic [31:0] crc_nxt_c
);

   logic [31:0] c;

   always_comb begin
      c = crc;
      for (int i = 0; i < 2; i++) begin
         if (c[0] ^ dibit[i]) c = (c >> 1) ^ CRC_POLY;
         else                 c = c >> 1;
      end
      crc_nxt_c = c;
   end

endmodule

// File: rtl/ether_tx_driver.sv
// RMII transmitter: one minimum-size Ethernet frame per accepted 32-bit word.
// Outputs are decoded from next state/counter and registered once, so txen rises the cycle after accept.
module ether_tx_driver #(
   parameter logic [47:0] DST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
   parameter logic [47:0] SRC_MAC   = 48'h69_69_5A_06_54_91,
   parameter logic [15:0] ETHERTYPE = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        axiiv,
   input  logic [31:0] axiid,
   output logic        axiir,
   output logic        eth_txen,
   output logic [1:0]  eth_txd
);

   import ether_pkg::*;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [31:0]        hold;
   logic [31:0]        crc, crc_base, crc_upd, fcs_word;
   logic [HDR_W-1:0]   hdr;
   logic [7:0]         byte_v;
   logic [1:0]         dibit_c;
   logic               txen_c;
   logic               crc_en;
   logic               accept;

   assign hdr      = {DST_MAC, SRC_MAC, ETHERTYPE};
   assign axiir    = !rst && (state == IDLE);
   assign accept   = axiiv && axiir;
   assign fcs_word = ~crc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Sequencing; IFG state runs one short because the IDLE accept cycle completes the gap.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (accept) state_nxt = PREAMBLE;
         end
         PREAMBLE: if (cnt == CNT_W'(PREAMBLE_DIBITS - 1)) begin
            state_nxt = HEADER;
            cnt_nxt   = '0;
         end
         HEADER: if (cnt == CNT_W'(HEADER_DIBITS - 1)) begin
            state_nxt = PAYLOAD;
            cnt_nxt   = '0;
         end
         PAYLOAD: if (cnt == CNT_W'(PAYLOAD_DIBITS - 1)) begin
            state_nxt = FCS;
            cnt_nxt   = '0;
         end
         FCS: if (cnt == CNT_W'(FCS_DIBITS - 1)) begin
            state_nxt = IFG;
            cnt_nxt   = '0;
         end
         IFG: if (cnt == CNT_W'(IFG_CYCLES - 2)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Wire dibit for the upcoming cycle.
   always_comb begin
      dibit_c = 2'b00;
      txen_c  = 1'b0;
      crc_en  = 1'b0;
      byte_v  = 8'h00;
      case (state_nxt)
         PREAMBLE: begin
            txen_c  = 1'b1;
            dibit_c = (cnt_nxt == CNT_W'(PREAMBLE_DIBITS - 1)) ? SFD_DIBIT : PREAMBLE_DIBIT;
         end
         HEADER: begin
            txen_c  = 1'b1;
            crc_en  = 1'b1;
            byte_v  = hdr[(7'd111 - {cnt_nxt[5:2], 3'b000}) -: 8];
            dibit_c = byte_dibit(byte_v, cnt_nxt[1:0]);
         end
         PAYLOAD: begin
            txen_c = 1'b1;
            crc_en = 1'b1;
            if (cnt_nxt[7:2] < 6'(WORD_BYTES))
               byte_v = hold[(5'd31 - {cnt_nxt[3:2], 3'b000}) -: 8];
            dibit_c = byte_dibit(byte_v, cnt_nxt[1:0]);
         end
         FCS: begin
            txen_c  = 1'b1;
            dibit_c = fcs_word[{cnt_nxt[3:0], 1'b0} +: 2];
         end
         default: ;
      endcase
   end

   assign crc_base = (state_nxt == HEADER && state != HEADER) ? CRC_INIT : crc;

   crc32_dibit u_crc (
      .crc       (crc_base),
      .dibit     (dibit_c),
      .crc_nxt_c (crc_upd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         crc      <= CRC_INIT;
         hold     <= '0;
         eth_txen <= 1'b0;
         eth_txd  <= 2'b00;
      end else begin
         eth_txen <= txen_c;
         eth_txd  <= dibit_c;
         if (accept) hold <= axiid;
         if (crc_en) crc  <= crc_upd;
      end
   end

endmodule

// File: tb/tb_ether_tx_driver.sv
// Self-checking bench for ether_tx_driver against a byte-level Ethernet frame model.
module tb_ether_tx_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        axiiv;
   logic [31:0] axiid;
   logic        axiir;
   logic        eth_txen;
   logic [1:0]  eth_txd;

   int total = 0;
   int bad   = 0;

   logic [1:0] cap_d [0:287];
   logic       cap_en [0:287];
   logic [1:0] exp_d [0:287];
   logic       cap_tail_en;
   logic       pulse_ir;
   logic       tr_en [0:699];
   logic [1:0] tr_d  [0:699];

   always #10 clk = ~clk;

   ether_tx_driver dut (
      .clk      (clk),
      .rst      (rst),
      .axiiv    (axiiv),
      .axiid    (axiid),
      .axiir    (axiir),
      .eth_txen (eth_txen),
      .eth_txd  (eth_txd)
   );

   // Whole frame as bytes (preamble, header, padded payload, FCS), then split into wire dibits.
   task automatic build_expected(input logic [31:0] w);
      logic [7:0]  fb [0:71];
      logic [31:0] crc;
      logic [31:0] fcs;
      logic [47:0] dst;
      logic [47:0] src;
      dst = 48'hFF_FF_FF_FF_FF_FF;
      src = 48'h69_69_5A_06_54_91;
      for (int i = 0; i < 7; i++) fb[i] = 8'h55;
      fb[7] = 8'hD5;
      for (int i = 0; i < 6; i++) begin
         fb[8 + i]  = dst[47 - 8*i -: 8];
         fb[14 + i] = src[47 - 8*i -: 8];
      end
      fb[20] = 8'h08;
      fb[21] = 8'h00;
      for (int i = 0; i < 4; i++) fb[22 + i] = w[31 - 8*i -: 8];
      for (int i = 26; i < 68; i++) fb[i] = 8'h00;
      crc = 32'hFFFF_FFFF;
      for (int i = 8; i < 68; i++)
         for (int k = 0; k < 8; k++)
            crc = (crc[0] ^ fb[i][k]) ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
      fcs = ~crc;
      for (int j = 0; j < 4; j++) fb[68 + j] = fcs[8*j +: 8];
      for (int i = 0; i < 72; i++)
         for (int k = 0; k < 4; k++)
            exp_d[4*i + k] = fb[i][2*k +: 2];
   endtask

   function automatic logic [31:0] capture_residue();
      logic [31:0] crc;
      crc = 32'hFFFF_FFFF;
      for (int i = 32; i < 288; i++)
         for (int k = 0; k < 2; k++)
            crc = (crc[0] ^ cap_d[i][k]) ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
      return crc;
   endfunction

   function automatic int count_en();
      int n;
      n = 0;
      for (int i = 0; i < 288; i++) if (cap_en[i] === 1'b1) n++;
      return n;
   endfunction

   function automatic int first_frame_diff();
      for (int i = 0; i < 288; i++) if (cap_d[i] !== exp_d[i]) return i;
      return -1;
   endfunction

   task automatic wait_ready();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         if (axiir === 1'b1) ok = 1'b1;
         else @(negedge clk);
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL ready_timeout: axiir=%b, wanted 1 within 2000 cycles", axiir);
      end
   endtask

   // Accept one word, then record 288 cycles starting with the first frame cycle.
   task automatic send_and_capture(input logic [31:0] w, input int pulse_at);
      wait_ready();
      axiid = w;
      axiiv = 1'b1;
      @(negedge clk);
      axiiv    = 1'b0;
      pulse_ir = 1'b0;
      for (int i = 0; i < 288; i++) begin
         cap_d[i]  = eth_txd;
         cap_en[i] = eth_txen;
         if (i == pulse_at) begin
            axiiv = 1'b1;
            axiid = $urandom();
            #1;
            if (axiir !== 1'b0) pulse_ir = 1'b1;
         end
         @(negedge clk);
         axiiv = 1'b0;
      end
      cap_tail_en = eth_txen;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      axiiv = 1'b0;
      axiid = 32'h0;
      repeat (3) @(negedge clk);
      total++;
      if (eth_txen !== 1'b0) begin bad++; $display("FAIL reset_txen: got=%b want=0", eth_txen); end
      total++;
      if (eth_txd !== 2'b00) begin bad++; $display("FAIL reset_txd: got=%b want=00", eth_txd); end
      total++;
      if (axiir !== 1'b0) begin bad++; $display("FAIL reset_axiir: got=%b want=0", axiir); end
      rst = 1'b0;
      #1;
      total++;
      if (axiir !== 1'b1) begin bad++; $display("FAIL reset_release_axiir: got=%b want=1", axiir); end
      @(negedge clk);
   endtask

   task automatic test_deadbeef();
      logic [1:0] pay [0:3];
      int n;
      int k;
      int diff;
      logic [31:0] res;
      pay[0] = 2'b10; pay[1] = 2'b11; pay[2] = 2'b01; pay[3] = 2'b11;
      build_expected(32'hDEAD_BEEF);
      send_and_capture(32'hDEAD_BEEF, -1);
      n = count_en();
      total++;
      if (n != 288) begin bad++; $display("FAIL dead_txen_len: got=%0d want=288", n); end
      total++;
      if (cap_tail_en !== 1'b0) begin bad++; $display("FAIL dead_txen_tail: got=%b want=0", cap_tail_en); end
      n = 0;
      for (int i = 0; i < 31; i++) if (cap_d[i] !== 2'b01) n++;
      if (cap_d[31] !== 2'b11) n++;
      total++;
      if (n != 0) begin bad++; $display("FAIL dead_preamble: bad dibits=%0d want=0 (sfd=%b)", n, cap_d[31]); end
      n = 0;
      for (int i = 32; i < 56; i++) if (cap_d[i] !== 2'b11) n++;
      total++;
      if (n != 0) begin bad++; $display("FAIL dead_dst_mac: bad dibits=%0d want=0", n); end
      n = 0;
      for (int i = 0; i < 4; i++) if (cap_d[88 + i] !== pay[i]) n++;
      total++;
      if (n != 0) begin
         bad++;
         $display("FAIL dead_first_byte: got=%b%b%b%b want=10110111", cap_d[88], cap_d[89], cap_d[90], cap_d[91]);
      end
      diff = first_frame_diff();
      total++;
      if (diff >= 0) begin bad++; $display("FAIL dead_frame: dibit %0d got=%b want=%b", diff, cap_d[diff], exp_d[diff]); end
      res = capture_residue();
      total++;
      if (res !== 32'hDEBB_20E3) begin bad++; $display("FAIL dead_residue: got=%h want=debb20e3", res); end
      // Idle gap: txen low and axiir low until IDLE, 48 low cycles in total.
      k = 1;
      n = 0;
      while (axiir !== 1'b1 && k < 200) begin
         if (eth_txen !== 1'b0) n++;
         @(negedge clk);
         k++;
      end
      total++;
      if (k != 48 || n != 0) begin bad++; $display("FAIL dead_ifg: gap=%0d txen_hi=%0d want gap=48 txen_hi=0", k, n); end
   endtask

   task automatic test_random_words();
      logic [31:0] w;
      logic [31:0] res;
      int diff;
      for (int r = 0; r < 4; r++) begin
         w = $urandom();
         build_expected(w);
         send_and_capture(w, -1);
         diff = first_frame_diff();
         total++;
         if (diff >= 0 || count_en() != 288) begin
            bad++;
            $display("FAIL rand_frame w=%h: first diff=%0d txen_cycles=%0d want diff=-1 cycles=288", w, diff, count_en());
         end
         res = capture_residue();
         total++;
         if (res !== 32'hDEBB_20E3) begin bad++; $display("FAIL rand_residue w=%h: got=%h want=debb20e3", w, res); end
      end
   endtask

   task automatic test_ignore_valid();
      logic [31:0] w;
      int diff;
      int k;
      int n;
      logic ir_seen;
      w = $urandom();
      build_expected(w);
      send_and_capture(w, 120);
      total++;
      if (pulse_ir !== 1'b0) begin bad++; $display("FAIL ign_payload_axiir: got=%b want=0", pulse_ir); end
      diff = first_frame_diff();
      total++;
      if (diff >= 0 || cap_tail_en !== 1'b0) begin
         bad++;
         $display("FAIL ign_frame: first diff=%0d tail=%b want diff=-1 tail=0", diff, cap_tail_en);
      end
      repeat (10) @(negedge clk);
      axiiv = 1'b1;
      axiid = $urandom();
      #1;
      ir_seen = axiir;
      @(negedge clk);
      axiiv = 1'b0;
      total++;
      if (ir_seen !== 1'b0) begin bad++; $display("FAIL ign_ifg_axiir: got=%b want=0", ir_seen); end
      k = 12;
      n = 0;
      while (axiir !== 1'b1 && k < 200) begin
         if (eth_txen !== 1'b0) n++;
         @(negedge clk);
         k++;
      end
      repeat (5) begin
         if (eth_txen !== 1'b0) n++;
         @(negedge clk);
      end
      total++;
      if (k != 48 || n != 0) begin bad++; $display("FAIL ign_ifg_timing: gap=%0d txen_hi=%0d want gap=48 txen_hi=0", k, n); end
   endtask

   task automatic test_back_to_back();
      int acc;
      int i;
      int len1;
      int gap;
      int s2;
      int len2;
      int n;
      wait_ready();
      axiid = 32'h1;
      axiiv = 1'b1;
      acc   = 0;
      for (int c = 0; c < 700; c++) begin
         if (axiiv === 1'b1 && axiir === 1'b1) acc++;
         @(negedge clk);
         if (acc == 1) axiid = 32'h2;
         if (acc >= 2) axiiv = 1'b0;
         tr_en[c] = eth_txen;
         tr_d[c]  = eth_txd;
      end
      axiiv = 1'b0;
      total++;
      if (acc != 2) begin bad++; $display("FAIL b2b_axiir_cycles: got=%0d want=2", acc); end
      i = 0;
      while (i < 700 && tr_en[i] === 1'b1) i++;
      len1 = i;
      while (i < 700 && tr_en[i] !== 1'b1) i++;
      gap = i - len1;
      s2  = i;
      while (i < 700 && tr_en[i] === 1'b1) i++;
      len2 = i - s2;
      total++;
      if (len1 != 288 || gap != 48 || len2 != 288) begin
         bad++;
         $display("FAIL b2b_timing: len1=%0d gap=%0d len2=%0d want 288/48/288", len1, gap, len2);
      end
      build_expected(32'h1);
      n = 0;
      for (int c = 0; c < 288; c++) if (tr_d[c] !== exp_d[c]) n++;
      total++;
      if (n != 0) begin bad++; $display("FAIL b2b_frame1: bad dibits=%0d want=0", n); end
      build_expected(32'h2);
      n = 0;
      for (int c = 0; c < 288; c++) if (s2 + c >= 700 || tr_d[s2 + c] !== exp_d[c]) n++;
      total++;
      if (n != 0) begin bad++; $display("FAIL b2b_frame2: bad dibits=%0d want=0", n); end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] res;
      int diff;
      wait_ready();
      axiid = $urandom();
      axiiv = 1'b1;
      @(negedge clk);
      axiiv = 1'b0;
      repeat (150) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (eth_txen !== 1'b0 || eth_txd !== 2'b00) begin
         bad++;
         $display("FAIL midrst_drop: txen=%b txd=%b want 0/00", eth_txen, eth_txd);
      end
      rst = 1'b0;
      #1;
      total++;
      if (axiir !== 1'b1) begin bad++; $display("FAIL midrst_axiir: got=%b want=1", axiir); end
      build_expected(32'h0);
      send_and_capture(32'h0, -1);
      diff = first_frame_diff();
      total++;
      if (diff >= 0 || count_en() != 288) begin
         bad++;
         $display("FAIL midrst_frame: first diff=%0d txen_cycles=%0d want -1/288", diff, count_en());
      end
      res = capture_residue();
      total++;
      if (res !== 32'hDEBB_20E3) begin bad++; $display("FAIL midrst_residue: got=%h want=debb20e3", res); end
   endtask

   initial begin
      test_reset();
      test_deadbeef();
      test_random_words();
      test_ignore_valid();
      test_back_to_back();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
